cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a button level.
REQ-002 SHALL provide parameter LEVEL_0_DIV, default 50_000_000, CPU enable period in clk cycles at level 0 (slowest).
REQ-003 SHALL provide parameter LEVEL_1_DIV, default 25_000_000, enable period at level 1.
REQ-004 SHALL provide parameter LEVEL_2_DIV, default 12_500_000, enable period at level 2.
REQ-005 SHALL provide parameter LEVEL_3_DIV, default 1, enable period at level 3 (fastest; 1 = every cycle).
REQ-006 SHALL have port clk  input  1  fastest system clock; single clock domain, all state on posedge clk.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have ports btn_faster / btn_slower  input  1 each  raw asynchronous push buttons, raise / lower speed level.
REQ-009 SHALL have port btn_run  input  1  raw button, toggles RUN/HALT.
REQ-010 SHALL have port btn_step  input  1  raw button, single-step request while halted.
REQ-011 SHALL have port halt_req  input  1  synchronous CPU halt request (e.g. syscall exit), level-sensitive.
REQ-012 SHALL have port cpu_clk_en  output  1  one-cycle clock-enable pulse that advances the CPU by one instruction cycle.
REQ-013 SHALL have ports level  output  2  current speed level, and mode  output  2  current FSM state (HALT=0, RUN=1, STEP=2).

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level changes only after the synchronized input holds the new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced 0->1 transition; releases produce no event.
REQ-016 level SHALL increment on a faster event, saturating at 3, and decrement on a slower event, saturating at 0.
REQ-017 Simultaneous faster and slower events SHALL leave level unchanged.
REQ-018 Divider counter SHALL count 0..DIV[level]-1 and wrap to 0; the terminal-count cycle is the tick.
REQ-019 Any level change SHALL clear the divider to 0 in the same cycle the new level is registered.
REQ-020 Divider SHALL run only in RUN; it SHALL be held at 0 in HALT and STEP.
REQ-021 FSM HALT: run event -> RUN; step event -> STEP; otherwise stay; run event takes priority over step event.
REQ-022 FSM RUN: halt_req or run event -> HALT; otherwise stay; step events ignored.
REQ-023 FSM STEP: unconditional -> HALT after one cycle; all button events in that cycle ignored.
REQ-024 cpu_clk_en SHALL be registered and assert for exactly one cycle: the cycle after a RUN tick, or the cycle after entering STEP.
REQ-025 cpu_clk_en SHALL never assert in HALT except for a pulse already scheduled by REQ-024; halt_req in RUN cancels no pulse already scheduled.
REQ-026 With DIV=1 in RUN, cpu_clk_en SHALL be high every cycle from the second RUN cycle onward.
REQ-027 DIV parameters SHALL be >= 1; divider width SHALL be 32 bits, no overflow for any legal DIV.

Reset
REQ-028 On rst: mode=HALT, level=0, divider=0, cpu_clk_en=0, synchronizer and debouncer state=0 (buttons read as released).
REQ-029 rst asserted mid-run or mid-step SHALL take effect on the next posedge and suppress any pending cpu_clk_en.
REQ-030 A button held through reset release SHALL generate one press event after DEBOUNCE_CYCLES.

Structure
REQ-031 Shared package SHALL hold mode encodings (HALT/RUN/STEP), level width, and level-count constant.
REQ-032 One sub-module btn_debounce (synchronizer + debouncer + rising-edge pulse) SHALL be instantiated four times.
REQ-033 Level register, divider, and mode FSM SHALL live in cpu_run_controller; target 150-300 lines total RTL.

Verification (DEBOUNCE_CYCLES=4, DIV=8,4,2,1)
REQ-034 Reset, btn_run held 10 cycles -> mode=RUN; cpu_clk_en pulses every 8 cycles, level=0.
REQ-035 In RUN, two faster presses -> level=2; pulses every 2 cycles, divider restarts at each change; five faster presses -> level stays 3.
REQ-036 HALT, btn_step held 10 cycles -> exactly one cpu_clk_en pulse, mode returns to 0; btn_step glitch of 2 cycles -> no pulse.
REQ-037 RUN at level 3, halt_req asserted 1 cycle -> mode=HALT next cycle, no further pulses after the one already scheduled.
REQ-038 faster and slower pressed identically -> level unchanged; btn_run and btn_step together in HALT -> RUN.
REQ-039 rst asserted the cycle after STEP entry -> cpu_clk_en stays 0, mode=HALT, level=0.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared encodings for the CPU run controller: mode values and speed-level sizing.
package cpu_run_controller_pkg;

  localparam int unsigned LevelWidth = 2;
  localparam int unsigned NumLevels  = 4;

  typedef enum logic [1:0] {
    ModeHalt = 2'd0,
    ModeRun  = 2'd1,
    ModeStep = 2'd2
  } mode_e;

endpackage

// File: rtl/cpu_run_controller_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debouncer and a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic [31:0] cnt_q, cnt_d;

  // cnt counts consecutive cycles the synchronized input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 1) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt/step controller that paces the CPU with a clock-enable at one of four speed levels.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LEVEL_0_DIV     = 50_000_000,
  parameter int unsigned LEVEL_1_DIV     = 25_000_000,
  parameter int unsigned LEVEL_2_DIV     = 12_500_000,
  parameter int unsigned LEVEL_3_DIV     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_faster,
  input  logic       btn_slower,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       halt_req,
  output logic       cpu_clk_en,
  output logic [1:0] level,
  output logic [1:0] mode
);

  logic ev_faster, ev_slower, ev_run, ev_step;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_faster (
    .clk(clk), .rst(rst), .btn(btn_faster), .press(ev_faster)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slower (
    .clk(clk), .rst(rst), .btn(btn_slower), .press(ev_slower)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst(rst), .btn(btn_run), .press(ev_run)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst(rst), .btn(btn_step), .press(ev_step)
  );

  mode_e                 mode_q, mode_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic [31:0]           div_q, div_d, div_max;
  logic                  en_q, en_d;
  logic                  tick;

  always_comb begin
    div_max = 32'(LEVEL_0_DIV - 1);
    unique case (level_q)
      2'd0: div_max = 32'(LEVEL_0_DIV - 1);
      2'd1: div_max = 32'(LEVEL_1_DIV - 1);
      2'd2: div_max = 32'(LEVEL_2_DIV - 1);
      2'd3: div_max = 32'(LEVEL_3_DIV - 1);
      default: div_max = 32'(LEVEL_0_DIV - 1);
    endcase
  end

  // The STEP cycle swallows every button event, speed buttons included.
  always_comb begin
    level_d = level_q;
    if (mode_q != ModeStep) begin
      if (ev_faster && !ev_slower && level_q != LevelWidth'(NumLevels - 1)) begin
        level_d = level_q + 1'b1;
      end else if (ev_slower && !ev_faster && level_q != '0) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      ModeHalt: begin
        if (ev_run) begin
          mode_d = ModeRun;
        end else if (ev_step) begin
          mode_d = ModeStep;
        end
      end
      ModeRun:  if (halt_req || ev_run) mode_d = ModeHalt;
      ModeStep: mode_d = ModeHalt;
      default:  mode_d = ModeHalt;
    endcase
  end

  // Divider only advances while staying in RUN at an unchanged level.
  always_comb begin
    tick  = (mode_q == ModeRun) && (div_q == div_max);
    div_d = '0;
    if (mode_q == ModeRun && mode_d == ModeRun && level_d == level_q && !tick) begin
      div_d = div_q + 32'd1;
    end
    en_d = tick || (mode_q == ModeStep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= ModeHalt;
      level_q <= '0;
      div_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      level_q <= level_d;
      div_q   <= div_d;
      en_q    <= en_d;
    end
  end

  assign cpu_clk_en = en_q;
  assign level      = level_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized scoreboard bench for cpu_run_controller against a behavioural reference model.
module tb_cpu_run_controller;

  localparam int DB = 4;
  localparam int HALT = 0, RUN = 1, STEP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt_req = 1'b0;
  logic [3:0] btns = 4'b0000;  // [0]=faster [1]=slower [2]=run [3]=step
  logic       cpu_clk_en;
  logic [1:0] level, mode;

  int tests = 0;
  int fails = 0;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES(DB),
    .LEVEL_0_DIV(8),
    .LEVEL_1_DIV(4),
    .LEVEL_2_DIV(2),
    .LEVEL_3_DIV(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_faster(btns[0]),
    .btn_slower(btns[1]),
    .btn_run(btns[2]),
    .btn_step(btns[3]),
    .halt_req(halt_req),
    .cpu_clk_en(cpu_clk_en),
    .level(level),
    .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_s1[4], m_s2[4], m_db[4];
  bit         m_hist[4][$];
  logic [3:0] m_ev = '0;
  int         m_mode = HALT, m_level = 0, m_phase = 0;
  logic [4:0] exp_q[$];

  function automatic int div_of(input int lv);
    case (lv)
      0: return 8;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  // Predicts the DUT outputs after the coming posedge, given the inputs just driven.
  task automatic model_step();
    logic [3:0] new_ev;
    bit f, s, r, st, pulse, flip;
    int nm, nl;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0;
        m_hist[i].delete();
      end
      m_ev = '0; m_mode = HALT; m_level = 0; m_phase = 0;
      exp_q.push_back(5'b0);
      return;
    end
    new_ev = '0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i].push_back(m_s2[i]);
      if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
      flip = (m_hist[i].size() == DB);
      for (int j = 0; j < m_hist[i].size(); j++) if (m_hist[i][j] == m_db[i]) flip = 0;
      if (flip) begin
        m_db[i] = !m_db[i];
        new_ev[i] = m_db[i];
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = btns[i];
    end
    f = m_ev[0]; s = m_ev[1]; r = m_ev[2]; st = m_ev[3];
    pulse = (m_mode == RUN && m_phase == div_of(m_level) - 1) || m_mode == STEP;
    nl = m_level;
    if (m_mode != STEP) begin
      if (f && !s) nl = (m_level < 3) ? m_level + 1 : 3;
      else if (s && !f) nl = (m_level > 0) ? m_level - 1 : 0;
    end
    nm = m_mode;
    if (m_mode == HALT) nm = r ? RUN : (st ? STEP : HALT);
    else if (m_mode == RUN) nm = (halt_req || r) ? HALT : RUN;
    else nm = HALT;
    m_phase = (m_mode == RUN && nm == RUN && nl == m_level) ? (m_phase + 1) % div_of(m_level) : 0;
    m_mode = nm;
    m_level = nl;
    m_ev = new_ev;
    exp_q.push_back({pulse, 2'(nm), 2'(nl)});
  endtask

  task automatic cyc(input logic [3:0] b, input logic h, input logic r);
    @(negedge clk);
    btns = b;
    halt_req = h;
    rst = r;
    model_step();
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    repeat (n) cyc(b, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({cpu_clk_en, mode, level} !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got en=%0b mode=%0d level=%0d want en=%0b mode=%0d level=%0d",
                   $time, cpu_clk_en, mode, level, e[4], e[3:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    int hc[4];
    logic [3:0] cur;
    bit reached;
    repeat (3) cyc(4'b0000, 1'b0, 1'b1);
    hold(4'b0000, 3);
    // RUN at level 0, then speed changes with saturation
    hold(4'b0100, 10); hold(4'b0000, 30);
    repeat (2) begin hold(4'b0001, 6); hold(4'b0000, 8); end
    hold(4'b0000, 10);
    repeat (5) begin hold(4'b0001, 6); hold(4'b0000, 6); end
    hold(4'b0000, 6);
    cyc(4'b0000, 1'b1, 1'b0);
    hold(4'b0000, 10);
    // Step, then a glitch that must not step
    hold(4'b1000, 10); hold(4'b0000, 10);
    hold(4'b1000, 2);  hold(4'b0000, 10);
    // Simultaneous speed buttons; run+step together from HALT
    hold(4'b0011, 6); hold(4'b0000, 8);
    hold(4'b1100, 6); hold(4'b0000, 12);
    hold(4'b0100, 6); hold(4'b0000, 8);
    // Reset during the STEP cycle
    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      cyc(4'b1000, 1'b0, 1'b0);
      if (m_mode == STEP) reached = 1;
    end
    if (!reached) begin
      fails++;
      $display("FAIL step_entry_bound got mode=%0d want %0d", m_mode, STEP);
    end
    cyc(4'b1000, 1'b0, 1'b1);
    hold(4'b0000, 6);
    // Button held through reset release
    repeat (3) cyc(4'b0100, 1'b0, 1'b1);
    hold(4'b0100, 10); hold(4'b0000, 20);
    // Randomized phase
    cur = '0;
    for (int i = 0; i < 4; i++) hc[i] = 0;
    repeat (2500) begin
      for (int i = 0; i < 4; i++) begin
        if (hc[i] == 0) begin
          cur[i] = ($urandom_range(0, 2) == 0);
          hc[i] = $urandom_range(1, 9);
        end else begin
          hc[i]--;
        end
      end
      cyc(cur, $urandom_range(0, 39) == 0, $urandom_range(0, 599) == 0);
    end
    hold(4'b0000, 3);
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
